// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sweep engine.
package tt_pkg;
   localparam int TT_WIDTH   = 16;
   localparam int NUM_INPUTS = 4;

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, RESULT} tt_state_e;

   // Combination idx 0 lands in the MSB, matching the netlist naming (e.g. 0x2A56).
   function automatic logic [NUM_INPUTS-1:0] tt_bit_pos(input logic [NUM_INPUTS-1:0] idx);
      return NUM_INPUTS'(TT_WIDTH - 1) - idx;
   endfunction
endpackage

// File: rtl/tt_sweep_capture_if.sv
// Control/result handshake and gate-under-test pins of the sweep engine.
interface tt_sweep_capture_if;
   import tt_pkg::*;
   logic                  start;
   logic [TT_WIDTH-1:0]   expected_tt;
   logic [NUM_INPUTS-1:0] gate_in;
   logic                  gate_out;
   logic                  busy;
   logic [TT_WIDTH-1:0]   tt;
   logic                  match;
   logic                  tt_valid;
   logic                  tt_ready;

   modport master (output start, expected_tt, gate_out, tt_ready,
                   input  gate_in, busy, tt, match, tt_valid);
   modport slave  (input  start, expected_tt, gate_out, tt_ready,
                   output gate_in, busy, tt, match, tt_valid);
endinterface

// File: rtl/tt_sample_vote.sv
// Samples the GUT output on consecutive enabled cycles and majority-votes the result.
module tt_sample_vote #(
   parameter int SAMPLES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic sample,
   output logic vote_valid,
   output logic vote_bit
);
   localparam logic [3:0] LAST = 4'(SAMPLES - 1);
   localparam logic [3:0] HALF = 4'(SAMPLES / 2);

   logic [3:0] scnt;
   logic [3:0] ones;
   logic [3:0] ones_nx;

   // The vote includes the sample taken in the last cycle itself.
   assign ones_nx    = ones + {3'b000, sample};
   assign vote_valid = en && (scnt == LAST);
   assign vote_bit   = ones_nx > HALF;

   always_ff @(posedge clk) begin
      if (!rst_n || !en || vote_valid) begin
         scnt <= '0;
         ones <= '0;
      end else begin
         scnt <= scnt + 4'd1;
         ones <= ones_nx;
      end
   end
endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all 16 input combinations through a 4-input GUT, builds its truth table
// and compares it against a reference captured at start.
module tt_sweep_capture import tt_pkg::*; #(
   parameter int SETTLE_CYCLES = 2,
   parameter int SAMPLES       = 3
) (
   input logic              clk,
   input logic              rst_n,
   tt_sweep_capture_if.slave bus
);
   localparam logic [7:0]            SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [NUM_INPUTS-1:0] IDX_LAST    = '1;

   tt_state_e             state, state_nx;
   logic [7:0]            settle_cnt;
   logic [NUM_INPUTS-1:0] idx;
   logic [TT_WIDTH-1:0]   tt_sr, exp_q, sr_shift;
   logic [NUM_INPUTS-1:0] gate_in_q;
   logic                  busy_q, valid_q, match_q;
   logic                  vote_valid, vote_bit, settle_done;

   tt_sample_vote #(.SAMPLES(SAMPLES)) u_vote (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (state == SAMPLE),
      .sample     (bus.gate_out),
      .vote_valid (vote_valid),
      .vote_bit   (vote_bit)
   );

   assign settle_done  = (settle_cnt == SETTLE_LAST);
   assign sr_shift     = {tt_sr[TT_WIDTH-2:0], vote_bit};
   assign bus.gate_in  = gate_in_q;
   assign bus.busy     = busy_q;
   assign bus.tt       = tt_sr;
   assign bus.match    = match_q;
   assign bus.tt_valid = valid_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:   if (bus.start)   state_nx = SETTLE;
         SETTLE: if (settle_done) state_nx = SAMPLE;
         SAMPLE: if (vote_valid)  state_nx = (idx == IDX_LAST) ? RESULT : SETTLE;
         RESULT: if (bus.tt_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         settle_cnt <= '0;
         idx        <= '0;
         tt_sr      <= '0;
         exp_q      <= '0;
         gate_in_q  <= '0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         match_q    <= 1'b0;
      end else begin
         busy_q  <= (state_nx == SETTLE) || (state_nx == SAMPLE);
         valid_q <= (state_nx == RESULT);
         unique case (state)
            IDLE: if (bus.start) begin
               exp_q      <= bus.expected_tt;
               tt_sr      <= '0;
               idx        <= '0;
               settle_cnt <= '0;
               gate_in_q  <= '0;
            end
            SETTLE: settle_cnt <= settle_done ? 8'd0 : settle_cnt + 8'd1;
            SAMPLE: if (vote_valid) begin
               tt_sr <= sr_shift;
               if (idx == IDX_LAST) begin
                  gate_in_q <= '0;
                  match_q   <= (sr_shift == exp_q);
               end else begin
                  idx       <= idx + 1'b1;
                  gate_in_q <= idx + 1'b1;
               end
            end
            RESULT: if (bus.tt_ready) match_q <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: default-parameter and SETTLE=1/SAMPLES=1 instances
// driven by behavioural GUTs and checked against a sweep-level reference model.
module tb_tt_sweep_capture;
   import tt_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   tt_sweep_capture_if bus ();
   tt_sweep_capture_if bus_p ();

   tt_sweep_capture dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   tt_sweep_capture #(.SETTLE_CYCLES(1), .SAMPLES(1)) dut_p (.clk(clk), .rst_n(rst_n), .bus(bus_p));

   logic        start_v [2] = '{1'b0, 1'b0};
   logic        ready_v [2] = '{1'b0, 1'b0};
   logic [15:0] exp_v   [2] = '{16'h0, 16'h0};
   int          gut_mode = 0;
   logic [15:0] gut_tab  = 16'h0;
   logic        force_en = 1'b0;
   logic        force_val = 1'b0;

   logic        o_valid [2], o_busy [2], o_match [2];
   logic [15:0] o_tt    [2];
   logic [3:0]  o_gi    [2];

   // Behavioural GUT: 0 = table lookup, 1 = gate_in[3], 2 = gate_in[0].
   function automatic logic gut_eval(input int mode, input logic [15:0] tab, input logic [3:0] gi);
      case (mode)
         1:       return gi[3];
         2:       return gi[0];
         default: return tab[tt_bit_pos(gi)];
      endcase
   endfunction

   assign bus.start         = start_v[0];
   assign bus.expected_tt   = exp_v[0];
   assign bus.tt_ready      = ready_v[0];
   assign bus.gate_out      = force_en ? force_val : gut_eval(gut_mode, gut_tab, bus.gate_in);
   assign bus_p.start       = start_v[1];
   assign bus_p.expected_tt = exp_v[1];
   assign bus_p.tt_ready    = ready_v[1];
   assign bus_p.gate_out    = gut_eval(gut_mode, gut_tab, bus_p.gate_in);

   assign o_valid[0] = bus.tt_valid;  assign o_valid[1] = bus_p.tt_valid;
   assign o_busy[0]  = bus.busy;      assign o_busy[1]  = bus_p.busy;
   assign o_match[0] = bus.match;     assign o_match[1] = bus_p.match;
   assign o_tt[0]    = bus.tt;        assign o_tt[1]    = bus_p.tt;
   assign o_gi[0]    = bus.gate_in;   assign o_gi[1]    = bus_p.gate_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: per combination, majority of the SAMPLES values seen in the sample
   // window, where cycle numbers in [g0, g0+glen) read the forced value instead.
   function automatic logic [15:0] model_tt(input int mode, input logic [15:0] tab, input int s,
                                            input int n, input int g0, input int glen);
      logic [15:0] r = '0;
      for (int i = 0; i < 16; i++) begin
         int ones = 0;
         for (int k = 0; k < n; k++) begin
            int cyc = 1 + (s + n) * i + s + k;
            ones += (cyc >= g0 && cyc < g0 + glen) ? 0 : int'(gut_eval(mode, tab, 4'(i)));
         end
         r[tt_bit_pos(4'(i))] = (ones > n / 2);
      end
      return r;
   endfunction

   task automatic chk_reset(input int sel);
      chk("rst_gate_in", o_gi[sel], 0);
      chk("rst_busy", o_busy[sel], 0);
      chk("rst_tt", o_tt[sel], 0);
      chk("rst_match", o_match[sel], 0);
      chk("rst_valid", o_valid[sel], 0);
   endtask

   task automatic run_sweep(input int sel, input logic [15:0] exp, input int s, input int n,
                            input int g0, input int glen, input int abort_n,
                            output logic [15:0] got_tt, output logic got_m, output int lat);
      int cyc;
      lat = -1; got_tt = '0; got_m = 1'b0;
      @(negedge clk); start_v[sel] = 1'b1; exp_v[sel] = exp;
      @(negedge clk); start_v[sel] = 1'b0; cyc = 1;
      chk("busy_rise", o_busy[sel], 1);
      chk("gate_in_first", o_gi[sel], 0);
      while (cyc < 4000) begin
         force_en = (sel == 0) && cyc >= g0 && cyc < g0 + glen;
         if (cyc == g0) chk("glitch_idx", o_gi[sel], (g0 - 1) / (s + n));
         if (cyc == abort_n) begin
            chk("abort_idx", o_gi[sel], (abort_n - 1) / (s + n));
            rst_n = 1'b0;
            @(negedge clk);
            chk_reset(0); chk_reset(1);
            rst_n = 1'b1;
            lat = 0;
            break;
         end
         if (o_valid[sel]) begin lat = cyc; break; end
         @(negedge clk); cyc++;
      end
      force_en = 1'b0;
      if (lat < 0) chk("timeout", 0, 1);
      else if (lat > 0) begin
         got_tt = o_tt[sel];
         got_m  = o_match[sel];
         chk("busy_fall", o_busy[sel], 0);
      end
   endtask

   task automatic handshake(input int sel);
      @(negedge clk); ready_v[sel] = 1'b1;
      @(negedge clk); ready_v[sel] = 1'b0;
      chk("valid_drop", o_valid[sel], 0);
   endtask

   initial begin
      logic [15:0] t, m, e;
      logic        mt;
      int          lat, sel, s, n;

      repeat (3) @(negedge clk);
      chk_reset(0); chk_reset(1);
      rst_n = 1'b1;

      // 0x2A56 GUT, defaults, then backpressure with ignored start pulses.
      gut_mode = 0; gut_tab = 16'h2A56;
      run_sweep(0, 16'h2A56, 2, 3, 0, 0, 0, t, mt, lat);
      chk("nor_tt", t, model_tt(0, 16'h2A56, 2, 3, 0, 0));
      chk("nor_match", mt, 1);
      chk("nor_lat", lat, 81);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         start_v[0] = (k == 5 || k == 6 || k == 12);
         chk("bp_tt", o_tt[0], 16'h2A56);
         chk("bp_match", o_match[0], 1);
         chk("bp_gate_in", o_gi[0], 0);
         chk("bp_valid", o_valid[0], 1);
         chk("bp_busy", o_busy[0], 0);
      end
      @(negedge clk); start_v[0] = 1'b1; ready_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0; ready_v[0] = 1'b0;
      chk("bp_valid_drop", o_valid[0], 0);
      chk("bp_no_restart", o_busy[0], 0);
      @(negedge clk);
      chk("bp_still_idle", o_busy[0], 0);

      // Simple GUTs against expected 0x0000.
      for (int md = 0; md < 3; md++) begin
         gut_mode = (md == 0) ? 1 : (md == 1) ? 2 : 0;
         gut_tab  = 16'h0000;
         m = model_tt(gut_mode, gut_tab, 2, 3, 0, 0);
         run_sweep(0, 16'h0000, 2, 3, 0, 0, 0, t, mt, lat);
         chk("simple_tt", t, m);
         chk("simple_match", mt, m == 16'h0000);
         handshake(0);
      end

      // Glitch rejection on a constant-1 GUT at idx 5: one then two forced zeros.
      gut_mode = 0; gut_tab = 16'hFFFF; force_val = 1'b0;
      for (int gl = 1; gl <= 2; gl++) begin
         run_sweep(0, 16'hFFFF, 2, 3, 28, gl, 0, t, mt, lat);
         chk("glitch_tt", t, model_tt(0, 16'hFFFF, 2, 3, 28, gl));
         chk("glitch_match", mt, gl == 1);
         handshake(0);
      end

      // Reset at idx 7 of a constant-1 sweep, then a clean 0x2A56 sweep.
      run_sweep(0, 16'hFFFF, 2, 3, 0, 0, 37, t, mt, lat);
      gut_tab = 16'h2A56;
      run_sweep(0, 16'h2A56, 2, 3, 0, 0, 0, t, mt, lat);
      chk("post_rst_tt", t, 16'h2A56);
      chk("post_rst_match", mt, 1);
      chk("post_rst_lat", lat, 81);
      handshake(0);

      // Minimal-parameter instance.
      run_sweep(1, 16'h2A56, 1, 1, 0, 0, 0, t, mt, lat);
      chk("p_tt", t, model_tt(0, 16'h2A56, 1, 1, 0, 0));
      chk("p_match", mt, 1);
      chk("p_lat", lat, 33);
      handshake(1);

      // Randomized GUTs on both instances.
      for (int i = 0; i < 10; i++) begin
         sel = i % 2;
         s = sel ? 1 : 2;
         n = sel ? 1 : 3;
         gut_mode = int'($urandom_range(0, 2));
         gut_tab  = 16'($urandom);
         m = model_tt(gut_mode, gut_tab, s, n, 0, 0);
         e = $urandom_range(0, 1) ? m : 16'($urandom);
         run_sweep(sel, e, s, n, 0, 0, 0, t, mt, lat);
         chk("rnd_tt", t, m);
         chk("rnd_match", mt, m == e);
         chk("rnd_lat", lat, 1 + 16 * (s + n));
         handshake(sel);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/tt_sweep_capture.md
# tt_sweep_capture

Truth-table characterization engine for 4-input combinational gate netlists. It drives all 16 input combinations into a gate-under-test (GUT) and samples its single output with a majority vote. It then assembles the 16-bit hex truth table in the same encoding used to name the netlists (for example 0x2A56) and compares it against an expected value. It sits on the verification/characterization side of the flow, reading back what the synthesized netlists implement.

## Interface
- `SETTLE_CYCLES`, default 2: cycles `gate_in` is held before sampling starts; valid range 1..255.
- `SAMPLES`, default 3: output samples per combination, majority-voted; must be odd, range 1..15.
- `clk  in  1  clock`.
- `rst_n  in  1  synchronous active-low reset`.
- `start  in  1  pulse/level; begins a sweep when accepted`.
- `expected_tt  in  16  reference truth table; captured on start acceptance`.
- `gate_in  out  4  GUT inputs; gate_in[3] = input _0 (MSB), gate_in[0] = input _3`.
- `gate_out  in  1  GUT output, same clock domain, combinational path`.
- `busy  out  1  sweep in progress`.
- `tt  out  16  captured truth table`.
- `match  out  1  tt == captured expected_tt; qualified by tt_valid`.
- `tt_valid  out  1  result available`.
- `tt_ready  in  1  consumer accepts result`.

## Operation
- Encoding: combination index idx = gate_in (0..15). The GUT output at idx lands in tt bit [15-idx]. Idx 0 is the MSB.
- FSM states: IDLE, SETTLE, SAMPLE, RESULT.
- IDLE: `gate_in`=0. A sweep is accepted when `start`=1. On acceptance:
  - latch `expected_tt`;
  - clear the shift register and idx;
  - go to SETTLE.
- SETTLE: drive `gate_in`=idx and count `SETTLE_CYCLES` cycles, then go to SAMPLE.
- SAMPLE: on each of `SAMPLES` consecutive cycles, add `gate_out` to a ones-count of width 4. On the last sample, the voted bit = (count > `SAMPLES`/2), including the current cycle's sample.
  - Shift left: tt_sr <= {tt_sr[14:0], vote}.
  - If idx==15, go to RESULT. Otherwise idx+1 and go to SETTLE. idx does not wrap inside a sweep.
- RESULT:
  - `tt_valid`=1;
  - `tt` = tt_sr, held stable;
  - `match` = (tt_sr == expected latch);
  - `gate_in`=0.
  - Stay here until `tt_valid`&&`tt_ready`, then go to IDLE.
- `start` is ignored in SETTLE, SAMPLE and RESULT. This includes the cycle in which the result handshake completes. No back-to-back restart happens in that cycle.
- `busy`=1 in SETTLE and SAMPLE only.
- Reset, including mid-sweep or with `tt_valid` pending, forces IDLE, discards the partial table and zeroes all counters.

## Timing
- Reset values: `gate_in`=0, `busy`=0, `tt`=0, `match`=0, `tt_valid`=0.
- All outputs are registered. `gate_in` changes only on entry to SETTLE or on return to IDLE/RESULT.
- Start accepted at edge t: `gate_in`=0 and `busy`=1 from cycle t+1.
- Per combination: `SETTLE_CYCLES`+`SAMPLES` cycles.
- `tt_valid` rises at cycle t+1+16·(`SETTLE_CYCLES`+`SAMPLES`); that is t+81 with the defaults.
- `busy` falls the same cycle `tt_valid` rises.
- `tt` and `match` are stable while `tt_valid`=1. `tt_valid` drops the cycle after the handshake.
- Earliest next acceptance is the cycle after `tt_valid` drops.

## Structure
- Package `tt_pkg` holds:
  - `TT_WIDTH`=16 and `NUM_INPUTS`=4;
  - the state enum (IDLE, SETTLE, SAMPLE, RESULT);
  - the function `tt_bit_pos(idx)` = 15-idx, used by the bench model.
- One sub-module, `tt_sample_vote`. It contains the sample counter, the ones-counter and the majority decision. Its outputs are a `vote_valid` pulse and `vote_bit`.
- The top level holds the FSM, the settle counter, idx, the shift register, the expected latch and the comparator.

## Test plan
- GUT = 0x2A56 NOR netlist with `expected_tt`=0x2A56 and defaults: `tt`=0x2A56, `match`=1, `tt_valid` at t+81.
- Simple GUTs with `expected_tt`=0x0000:
  - GUT `gate_out`=`gate_in`[3] gives `tt`=0x00FF, `match`=0;
  - GUT `gate_out`=`gate_in`[0] gives 0x5555;
  - GUT constant 0 gives 0x0000, `match`=1.
- Glitch rejection, `SAMPLES`=3, GUT constant 1: force `gate_out`=0 for one sample cycle at idx 5. Required: `tt`=0xFFFF. Two forced samples at idx 5 give 0xFBFF.
- Backpressure: hold `tt_ready`=0 for 20 cycles after `tt_valid` and pulse `start` during them. Required: `tt`, `match` and `gate_in`=0 stay stable, and no new sweep starts. Raising `tt_ready` gives `tt_valid`=0 the next cycle.
- Reset mid-sweep: assert `rst_n`=0 at idx 7. Required next cycle: all outputs at reset values. A new sweep of the 0x2A56 GUT then returns 0x2A56, with no residue from the aborted sweep.
- Parameter sweep with `SETTLE_CYCLES`=1, `SAMPLES`=1: `tt_valid` at t+33, `tt` correct for the 0x2A56 GUT.
